// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_rd_stream_pkg;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned CREDIT_W  = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_rd_stream.sv
// Drains a 1-cycle-latency FIFO read port into a first-word-fall-through ready/valid stream.
// Optional beat counter on the beat_cnt port when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_valid,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  proto_err
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

  occ_e                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  proto_err_q, proto_err_d;
  logic                  pop_c;
  logic                  push_c;
  logic [CREDIT_W-1:0]   credit_c;

  // Credit check, buffer/occupancy next state and error tracking.
  always_comb begin
    occ_d       = occ_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pop_c       = (occ_q != OCC_EMPTY) && m_ready;
    credit_c    = CREDIT_W'(occ_q) + CREDIT_W'(inflight_q) - CREDIT_W'(pop_c);
    fifo_rd_en  = ~fifo_empty && ~flush && ~rst && (credit_c < CREDIT_W'(BUF_DEPTH));
    inflight_d  = fifo_rd_en;
    push_c      = fifo_valid && inflight_q && ~flush;
    proto_err_d = proto_err_q || (fifo_valid && ~inflight_q);

    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (push_c) begin
            occ_d  = OCC_ONE;
            head_d = fifo_dout;
          end
        end
        OCC_ONE: begin
          if (push_c && !pop_c) begin
            occ_d  = OCC_TWO;
            tail_d = fifo_dout;
          end else if (push_c && pop_c) begin
            head_d = fifo_dout;
          end else if (pop_c) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // The credit rule never lets a push land here without a pop.
          if (pop_c) begin
            head_d = tail_q;
            if (push_c) begin
              tail_d = fifo_dout;
            end else begin
              occ_d = OCC_ONE;
            end
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q       <= OCC_EMPTY;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign m_valid   = (occ_q != OCC_EMPTY);
  assign m_data    = head_q;
  assign proto_err = proto_err_q;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  // Counts consumed beats, including a pop that coincides with flush.
  always_comb begin
    beat_cnt_d = beat_cnt_q + CNT_WIDTH'(pop_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule
